// File: rtl/lms_ctr_gpio_in_pkg.sv
// Shared constants for the LMS control-path GPIO input port.
// Covers the register address map and the edge-type selector encoding.
package lms_ctr_gpio_in_pkg;

   typedef logic [2:0] addr_t;

   localparam addr_t ADDR_DATA  = 3'd0;
   localparam addr_t ADDR_LIMIT = 3'd1;
   localparam addr_t ADDR_MASK  = 3'd2;
   localparam addr_t ADDR_EDGE  = 3'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lms_ctr_gpio_in_debounce.sv
// One input bit: two-flop synchronizer followed by a counter debouncer.
// The stable output follows the synchronized pin once it has disagreed for limit+1 cycles.
module lms_ctr_gpio_in_debounce
   import lms_ctr_gpio_in_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pin,
   input  logic [CNT_W-1:0] limit,
   output logic             stable
);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             stable_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= pin;
         sync2_reg <= sync1_reg;
      end
   end

   // A counter left above a newly lowered limit simply runs on and wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_reg <= 1'b0;
         cnt_reg    <= '0;
      end else if (sync2_reg == stable_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == limit) begin
         stable_reg <= sync2_reg;
         cnt_reg    <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign stable = stable_reg;

endmodule

// File: rtl/lms_ctr_gpio_in.sv
// Avalon-MM status input port: debounced pins, edge capture with write-1-to-clear,
// and a maskable level interrupt.
module lms_ctr_gpio_in
   import lms_ctr_gpio_in_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int CNT_W          = 16,
   parameter int DEBOUNCE_RESET = 1000,
   parameter int EDGE_TYPE      = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d_reg;
   logic [WIDTH-1:0] edge_bits;
   logic [WIDTH-1:0] clear_bits;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] edge_capture_reg;
   logic [CNT_W-1:0] limit_reg;
   logic [31:0]      readdata_reg;
   logic [31:0]      read_mux;
   logic             rd_en;
   logic             wr_en;
   logic             unused_writedata;

   assign rd_en = chipselect & ~read_n;
   assign wr_en = chipselect & ~write_n;
   assign unused_writedata = &{1'b0, writedata};

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         lms_ctr_gpio_in_debounce #(
            .CNT_W (CNT_W)
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[gi]),
            .limit   (limit_reg),
            .stable  (stable[gi])
         );
      end
   endgenerate

   generate
      if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
         assign edge_bits = ~stable & stable_d_reg;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
         assign edge_bits = stable ^ stable_d_reg;
      end else begin : g_edge_rise
         assign edge_bits = stable & ~stable_d_reg;
      end
   endgenerate

   assign clear_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d_reg     <= '0;
         edge_capture_reg <= '0;
      end else begin
         stable_d_reg     <= stable;
         // A newly detected edge beats a simultaneous software clear.
         edge_capture_reg <= (edge_capture_reg & ~clear_bits) | edge_bits;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         limit_reg <= CNT_W'(DEBOUNCE_RESET);
         mask_reg  <= '0;
      end else if (wr_en) begin
         if (address == ADDR_LIMIT) limit_reg <= writedata[CNT_W-1:0];
         if (address == ADDR_MASK)  mask_reg  <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA:  read_mux[WIDTH-1:0] = stable;
         ADDR_LIMIT: read_mux[CNT_W-1:0] = limit_reg;
         ADDR_MASK:  read_mux[WIDTH-1:0] = mask_reg;
         ADDR_EDGE:  read_mux[WIDTH-1:0] = edge_capture_reg;
         default:    read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata_reg <= '0;
      else          readdata_reg <= rd_en ? read_mux : '0;
   end

   assign readdata = readdata_reg;
   assign irq      = |(edge_capture_reg & mask_reg);

endmodule

// File: tb/tb_lms_ctr_gpio_in.sv
// Bench for lms_ctr_gpio_in: directed scenarios plus random pin/bus traffic,
// all compared cycle by cycle against a behavioural model of the port.
module tb_lms_ctr_gpio_in;
   import lms_ctr_gpio_in_pkg::*;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 16;
   localparam int DEB_RST = 1000;
   localparam int TB_EDGE = EDGE_RISE;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [2:0]       address = '0;
   logic             chipselect = 1'b0;
   logic             read_n = 1'b1;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = '0;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port = '0;
   logic             irq;

   int errors = 0;
   int checks = 0;

   lms_ctr_gpio_in #(
      .WIDTH          (WIDTH),
      .CNT_W          (CNT_W),
      .DEBOUNCE_RESET (DEB_RST),
      .EDGE_TYPE      (TB_EDGE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Behavioural model: pins seen two clocks late; a bit's debounced level flips
   // once the late pin has disagreed with it for limit+1 consecutive clocks.
   logic [WIDTH-1:0] m_seen1, m_seen2, m_stab, m_pend, m_cap, m_mask;
   int               m_dis[WIDTH];
   int               m_lim;
   logic [31:0]      m_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_seen1 = '0; m_seen2 = '0; m_stab = '0; m_pend = '0; m_cap = '0; m_mask = '0;
      for (int i = 0; i < WIDTH; i++) m_dis[i] = 0;
      m_lim = DEB_RST;
      m_rd  = '0;
   endtask

   task automatic model_edge();
      logic [WIDTH-1:0] ns;
      logic [WIDTH-1:0] clr;
      logic [WIDTH-1:0] rise, fall;
      ns  = m_stab;
      clr = '0;
      m_rd = '0;
      if (chipselect && !read_n) begin
         case (address)
            3'd0: m_rd = 32'(m_stab);
            3'd1: m_rd = 32'(m_lim);
            3'd2: m_rd = 32'(m_mask);
            3'd3: m_rd = 32'(m_cap);
            default: m_rd = '0;
         endcase
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (m_seen2[i] != m_stab[i]) begin
            if (m_dis[i] == m_lim) begin
               ns[i] = m_seen2[i];
               m_dis[i] = 0;
            end else begin
               m_dis[i] = (m_dis[i] + 1) % (1 << CNT_W);
            end
         end else begin
            m_dis[i] = 0;
         end
      end
      if (chipselect && !write_n) begin
         if (address == 3'd1) m_lim = int'(writedata[CNT_W-1:0]);
         if (address == 3'd3) clr = writedata[WIDTH-1:0];
      end
      m_cap = (m_cap & ~clr) | m_pend;
      if (chipselect && !write_n && address == 3'd2) m_mask = writedata[WIDTH-1:0];
      rise = ns & ~m_stab;
      fall = ~ns & m_stab;
      m_pend = (TB_EDGE == EDGE_RISE) ? rise : (TB_EDGE == EDGE_FALL) ? fall : (rise | fall);
      m_stab = ns;
      m_seen2 = m_seen1;
      m_seen1 = in_port;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      cyc();
      $display("wr addr=%0d data=%0h", a, d);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a);
      chipselect = 1'b1; read_n = 1'b0; address = a;
      cyc();
      $display("rd addr=%0d data=%0h", a, readdata);
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic apply_reset();
      #2 reset_n = 1'b0;
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      #1;
      model_reset();
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      apply_reset();

      // reset values
      bus_read(3'd1);
      check("rst_limit", readdata, 32'd1000);
      bus_read(3'd2);
      check("rst_mask", readdata, 32'd0);

      // L = 0: capture exactly three edges after the pin change
      bus_write(3'd1, 32'd0);
      bus_write(3'd2, 32'hF);
      in_port = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("l0_irq_early", 32'(irq), 32'd0);
      end
      cyc();
      check("l0_irq_k3", 32'(irq), 32'd1);
      bus_read(3'd3);
      check("l0_capture", readdata, 32'h1);
      bus_write(3'd3, 32'hF);

      // L = 5: short glitch rejected, long pulse captured at k+8
      bus_write(3'd1, 32'd5);
      in_port[2] = 1'b1;
      run(3);
      in_port[2] = 1'b0;
      run(15);
      bus_read(3'd0);
      check("glitch_data", readdata, 32'h1);
      bus_read(3'd3);
      check("glitch_capture", readdata, 32'h0);
      in_port[2] = 1'b1;
      run(8);
      check("pulse_irq_k7", 32'(irq), 32'd0);
      cyc();
      check("pulse_irq_k8", 32'(irq), 32'd1);
      cyc();
      in_port[2] = 1'b0;
      run(12);
      bus_write(3'd3, 32'hF);

      // mask gating
      bus_write(3'd2, 32'h0);
      in_port[1] = 1'b1;
      run(12);
      check("masked_irq", 32'(irq), 32'd0);
      bus_read(3'd3);
      check("masked_capture", readdata, 32'h2);
      bus_write(3'd2, 32'h2);
      check("unmask_irq", 32'(irq), 32'd1);
      bus_write(3'd3, 32'h2);
      check("clear_irq", 32'(irq), 32'd0);

      // clear write colliding with a new edge on the same bit
      in_port[1] = 1'b0; run(12);
      in_port[1] = 1'b1; run(12);
      in_port[1] = 1'b0; run(12);
      in_port[1] = 1'b1;
      run(8);
      bus_write(3'd3, 32'h2);
      check("collide_irq", 32'(irq), 32'd1);
      bus_read(3'd3);
      check("collide_capture", readdata, 32'h2);

      // unused address and read-only data register
      bus_read(3'd5);
      check("addr5", readdata, 32'd0);
      bus_write(3'd0, 32'hF);
      bus_read(3'd0);
      check("data_ro", readdata, 32'h3);

      // asynchronous reset in the middle of a debounce count
      bus_write(3'd1, 32'd20);
      in_port = 4'b0100;
      run(5);
      chipselect = 1'b1; read_n = 1'b0; address = 3'd1;
      cyc();
      check("pre_reset_rd", readdata, 32'd20);
      apply_reset();
      bus_read(3'd1);
      check("post_reset_limit", readdata, 32'd1000);
      bus_read(3'd3);
      check("post_reset_capture", readdata, 32'd0);

      // random traffic
      bus_write(3'd1, 32'd2);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, WIDTH-1)] ^= 1'b1;
         case ($urandom_range(0, 9))
            0, 1: begin
               chipselect = 1'b1; read_n = 1'b0; address = 3'($urandom_range(0, 7));
            end
            2: begin
               chipselect = 1'b1; write_n = 1'b0; address = 3'($urandom_range(0, 7));
               writedata = $urandom & 32'hFFFF_0007;
               if ($urandom_range(0, 1) == 1) read_n = 1'b0;
            end
            default: ;
         endcase
         if (address == 3'd1 && !write_n && $urandom_range(0, 7) != 0) write_n = 1'b1;
         cyc();
         chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
